sn_stream_gen: RTL and testbench

Parametrised binary-to-stochastic stream generator for the NN wrapper. It converts `N_CH` unsigned `BW`-bit operands into `N_CH` parallel unipolar bit streams of length `2**BW`. Within each stream the number of ones equals the operand value exactly; each one is placed by a ruler-sequence bit select.
- Operands are latched at start.
- Generation supports single-period or continuous mode, downstream hold (back-pressure), abort, and a completion pulse.
- Feeds the stochastic multiply/accumulate stages.

---
 rtl/sn_gen_pkg.sv | 18 +
 rtl/sn_bit_select.sv | 20 ++
 rtl/sn_stream_gen.sv | 79 +++++++
 tb/tb_sn_stream_gen.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sn_gen_pkg.sv
// sn_gen_pkg: shared state type and ruler-sequence helpers for the stochastic stream generator.
package sn_gen_pkg;
  typedef enum logic {IDLE, GEN} sn_state_e;
  localparam int BW_MAX = 8;
  function automatic int stream_len(input int bw);
    return 1 << bw;
  endfunction
  function automatic logic [3:0] trailing_ones(input logic [BW_MAX-1:0] c, input int bw);
    logic [3:0] t;
    logic run;
    t = '0;
    run = 1'b1;
    for (int i = 0; i < BW_MAX; i++)
      if (run && i < bw && c[i]) t = t + 1'b1;
      else run = 1'b0;
    return t;
  endfunction
endpackage

// File: rtl/sn_bit_select.sv
// sn_bit_select: picks operand bit BW-1-t (t = trailing ones of c); the all-ones position yields 0.
module sn_bit_select
  import sn_gen_pkg::*;
#(
  parameter int BW = 4
) (
  input  logic [BW-1:0] x,
  input  logic [BW-1:0] c,
  output logic          b
);
  logic [3:0]      t;
  logic [BW_MAX:0] r;
  // r holds x bit-reversed so r[t] = x[BW-1-t]; r[BW] stays 0 for c = L-1
  always_comb begin
    t = trailing_ones(BW_MAX'(c), BW);
    r = '0;
    for (int j = 0; j < BW; j++) r[j] = x[BW-1-j];
    b = r[t];
  end
endmodule

// File: rtl/sn_stream_gen.sv
// sn_stream_gen: converts N_CH unsigned operands into parallel unipolar streams of length 2**BW.
module sn_stream_gen
  import sn_gen_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int BW   = 4
) (
  input  logic                      i_clk_fsm_mux,
  input  logic                      i_rst_fsm_mux,
  input  logic                      i_start,
  input  logic [N_CH-1:0][BW-1:0]   i_x_bn,
  input  logic                      i_cont,
  input  logic                      i_hold,
  input  logic                      i_stop,
  output logic                      o_busy,
  output logic                      o_isgen,
  output logic [N_CH-1:0]           o_sn_bit,
  output logic [BW-1:0]             o_idx,
  output logic                      o_done
);
  localparam int L = stream_len(BW);
  sn_state_e                 state_q, state_d;
  logic [BW-1:0]             c_q, c_d;
  logic [N_CH-1:0][BW-1:0]   x_q, x_d;
  logic                      cont_q, cont_d;
  logic                      gen, last;
  logic [N_CH-1:0]           sel;
  assign gen      = state_q == GEN;
  assign last     = c_q == BW'(L-1);
  assign o_busy   = gen;
  assign o_idx    = c_q;
  assign o_isgen  = gen & ~i_hold & ~i_stop;
  assign o_done   = o_isgen & last;
  assign o_sn_bit = sel & {N_CH{o_isgen}};
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    sn_bit_select #(.BW(BW)) u_sel (.x(x_q[i]), .c(c_q), .b(sel[i]));
  end
  always_ff @(posedge i_clk_fsm_mux or posedge i_rst_fsm_mux) begin
    if (i_rst_fsm_mux) begin
      state_q <= IDLE;
      c_q     <= '0;
      x_q     <= '0;
      cont_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      x_q     <= x_d;
      cont_q  <= cont_d;
    end
  end
  // c_q + 1 wraps to 0 at L-1, which is exactly the period boundary
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    x_d     = x_q;
    cont_d  = cont_q;
    if (!gen) begin
      if (i_start) begin
        state_d = GEN;
        c_d     = '0;
        x_d     = i_x_bn;
        cont_d  = i_cont;
      end
    end else if (i_stop) begin
      state_d = IDLE;
      c_d     = '0;
    end else if (!i_hold) begin
      c_d = c_q + 1'b1;
      if (last) begin
        if (cont_q) begin
          x_d    = i_x_bn;
          cont_d = i_cont;
        end else begin
          state_d = IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_sn_stream_gen.sv
// tb_sn_stream_gen: scoreboard bench for sn_stream_gen (BW=4 main instance, BW=3/6 sweep instances).
module tb_sn_stream_gen;
  localparam int N = 4;
  localparam int W = 4;
  localparam int L = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, cont = 1'b0, hold = 1'b0, stop = 1'b0;
  logic [N-1:0][W-1:0] x = '0;
  logic busy, isgen, done;
  logic [N-1:0] sn;
  logic [W-1:0] idx;
  logic s3 = 1'b0, s6 = 1'b0;
  logic [2:0] x3 = '0;
  logic [5:0] x6 = '0;
  logic b3, g3, d3, b6, g6, d6;
  logic [0:0] sn3, sn6;
  logic [2:0] idx3;
  logic [5:0] idx6;
  always #5 clk = ~clk;
  sn_stream_gen #(.N_CH(N), .BW(W)) dut (
    .i_clk_fsm_mux(clk), .i_rst_fsm_mux(rst), .i_start(start), .i_x_bn(x), .i_cont(cont),
    .i_hold(hold), .i_stop(stop), .o_busy(busy), .o_isgen(isgen), .o_sn_bit(sn), .o_idx(idx), .o_done(done));
  sn_stream_gen #(.N_CH(1), .BW(3)) dut3 (
    .i_clk_fsm_mux(clk), .i_rst_fsm_mux(rst), .i_start(s3), .i_x_bn(x3), .i_cont(1'b0),
    .i_hold(1'b0), .i_stop(1'b0), .o_busy(b3), .o_isgen(g3), .o_sn_bit(sn3), .o_idx(idx3), .o_done(d3));
  sn_stream_gen #(.N_CH(1), .BW(6)) dut6 (
    .i_clk_fsm_mux(clk), .i_rst_fsm_mux(rst), .i_start(s6), .i_x_bn(x6), .i_cont(1'b0),
    .i_hold(1'b0), .i_stop(1'b0), .o_busy(b6), .o_isgen(g6), .o_sn_bit(sn6), .o_idx(idx6), .o_done(d6));
  typedef struct packed {
    logic busy, isgen, done;
    logic [W-1:0] idx;
    logic [N-1:0] sn;
  } obs_t;
  obs_t sb[$];
  int n_chk = 0, n_fail = 0, cyc = 0, k0 = 0;
  int cnt[N];
  logic [L-1:0] mask[N];
  int ndone, done_at, nvalid;
  logic m_gen = 1'b0, m_cont = 1'b0;
  logic [W-1:0] m_c = '0;
  logic [N-1:0][W-1:0] m_x = '0;
  logic [N-1:0][W-1:0] xa = {4'd5, 4'd8, 4'd15, 4'd0};
  logic [N-1:0][W-1:0] xb = {4'd3, 4'd9, 4'd12, 4'd6};
  logic [N-1:0][W-1:0] x_3 = {4{4'd3}};
  logic [N-1:0][W-1:0] x_12 = {4{4'd12}};
  logic [N-1:0][W-1:0] x_0 = '0;
  function automatic logic ref_bit(input logic [W-1:0] v, input logic [W-1:0] c);
    logic [W-1:0] cc, s;
    int t;
    cc = c;
    t = 0;
    while (t < W && cc[0]) begin
      t++;
      cc = cc >> 1;
    end
    if (t == W) return 1'b0;
    s = v >> (W - 1 - t);
    return s[0];
  endfunction
  task automatic clr();
    for (int ch = 0; ch < N; ch++) begin
      cnt[ch] = 0;
      mask[ch] = '0;
    end
    ndone = 0;
    done_at = -1;
    nvalid = 0;
  endtask
  task automatic model_reset();
    m_gen = 1'b0;
    m_c = '0;
    m_x = '0;
    m_cont = 1'b0;
    sb.delete();
  endtask
  // one clock of the main DUT: push expectation, compare at negedge, advance model
  task automatic cycle(input logic st, input logic [N-1:0][W-1:0] xv, input logic ct, input logic hd, input logic sp);
    obs_t e, o;
    start = st; x = xv; cont = ct; hold = hd; stop = sp;
    e.busy = m_gen;
    e.isgen = m_gen & ~hd & ~sp;
    e.idx = m_c;
    e.done = e.isgen & (m_c == W'(L-1));
    for (int ch = 0; ch < N; ch++) e.sn[ch] = e.isgen & ref_bit(m_x[ch], m_c);
    sb.push_back(e);
    @(negedge clk);
    o = {busy, isgen, done, idx, sn};
    e = sb.pop_front();
    n_chk++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL cycle %0d busy/isgen/done/idx/sn got %b/%b/%b/%0d/%b expected %b/%b/%b/%0d/%b",
               cyc, o.busy, o.isgen, o.done, o.idx, o.sn, e.busy, e.isgen, e.done, e.idx, e.sn);
    end
    if (isgen) begin
      nvalid++;
      for (int ch = 0; ch < N; ch++) if (sn[ch]) begin
        cnt[ch]++;
        mask[ch][idx] = 1'b1;
      end
    end
    if (done) begin
      ndone++;
      done_at = cyc - k0;
    end
    if (m_gen) begin
      if (sp) begin
        m_gen = 1'b0;
        m_c = '0;
      end else if (!hd) begin
        if (m_c == W'(L-1)) begin
          m_c = '0;
          if (m_cont) begin
            m_x = xv;
            m_cont = ct;
          end else m_gen = 1'b0;
        end else m_c = m_c + 1'b1;
      end
    end else if (st) begin
      m_gen = 1'b1;
      m_c = '0;
      m_x = xv;
      m_cont = ct;
      k0 = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic check_counts(input string name, input logic [N-1:0][W-1:0] xv);
    for (int ch = 0; ch < N; ch++) begin
      n_chk++;
      if (cnt[ch] !== int'(xv[ch])) begin
        n_fail++;
        $display("FAIL %s ch%0d ones got %0d expected %0d", name, ch, cnt[ch], int'(xv[ch]));
      end
    end
  endtask
  task automatic check_done(input string name, input int nd, input int at);
    n_chk++;
    if (ndone !== nd || (at >= 0 && done_at !== at)) begin
      n_fail++;
      $display("FAIL %s done count/cycle got %0d/%0d expected %0d/%0d", name, ndone, done_at, nd, at);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({busy, isgen, done, idx, sn} !== '0) begin
      n_fail++;
      $display("FAIL reset outputs got %b expected 0", {busy, isgen, done, idx, sn});
    end
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    cycle(1'b0, x_0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, xa, 1'b0, 1'b1, 1'b1);
  endtask
  task automatic test_ones_count();
    clr();
    cycle(1'b1, xa, 1'b0, 1'b0, 1'b0);
    repeat (L) cycle(1'b0, x_0, 1'b0, 1'b0, 1'b0);
    check_counts("ones", {4'd5, 4'd8, 4'd15, 4'd0});
    n_chk++;
    if (mask[2] !== 16'h5555 || mask[3] !== 16'h22A2) begin
      n_fail++;
      $display("FAIL ones positions ch2/ch3 got %h/%h expected 5555/22a2", mask[2], mask[3]);
    end
    check_done("ones", 1, 16);
    cycle(1'b0, x_0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic test_back_to_back();
    logic [N-1:0][W-1:0] xv;
    for (int v = 0; v < L; v++) begin
      xv = {N{W'(v)}};
      clr();
      cycle(1'b1, xv, 1'b0, 1'b0, 1'b0);
      repeat (L) cycle(1'b0, x_0, 1'b0, 1'b0, 1'b0);
      check_counts("sweep", xv);
      check_done("sweep", 1, 16);
    end
    cycle(1'b0, x_0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic test_hold();
    clr();
    cycle(1'b1, xa, 1'b0, 1'b0, 1'b0);
    repeat (6) cycle(1'b0, x_0, 1'b0, 1'b0, 1'b0);
    repeat (3) begin
      cycle(1'b0, x_0, 1'b0, 1'b1, 1'b0);
      n_chk++;
      if (idx !== 4'd6) begin
        n_fail++;
        $display("FAIL hold idx got %0d expected 6", idx);
      end
    end
    repeat (10) cycle(1'b0, x_0, 1'b0, 1'b0, 1'b0);
    check_counts("hold", xa);
    check_done("hold", 1, 19);
    cycle(1'b0, x_0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic test_stop();
    clr();
    cycle(1'b1, xb, 1'b0, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, x_0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, xa, 1'b0, 1'b0, 1'b0);
    repeat (5) cycle(1'b0, x_0, 1'b0, 1'b0, 1'b0);
    n_chk++;
    if (idx !== 4'd9) begin
      n_fail++;
      $display("FAIL stop position got %0d expected 9", idx);
    end
    cycle(1'b0, x_0, 1'b0, 1'b0, 1'b1);
    n_chk++;
    if (busy !== 1'b0 || idx !== 4'd0) begin
      n_fail++;
      $display("FAIL stop busy/idx got %b/%0d expected 0/0", busy, idx);
    end
    cycle(1'b0, x_0, 1'b0, 1'b0, 1'b0);
    check_done("stop", 0, -1);
    clr();
    cycle(1'b1, xa, 1'b0, 1'b0, 1'b1);
    repeat (L) cycle(1'b0, x_0, 1'b0, 1'b0, 1'b0);
    check_counts("restart", xa);
    check_done("restart", 1, 16);
    cycle(1'b0, x_0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic test_continuous();
    clr();
    cycle(1'b1, x_3, 1'b1, 1'b0, 1'b0);
    repeat (L) cycle(1'b0, x_12, 1'b1, 1'b0, 1'b0);
    check_counts("cont p1", x_3);
    check_done("cont p1", 1, 16);
    n_chk++;
    if (nvalid !== L) begin
      n_fail++;
      $display("FAIL cont p1 valid cycles got %0d expected %0d", nvalid, L);
    end
    clr();
    repeat (L) cycle(1'b0, x_12, 1'b1, 1'b0, 1'b0);
    check_counts("cont p2", x_12);
    check_done("cont p2", 1, -1);
    n_chk++;
    if (nvalid !== L) begin
      n_fail++;
      $display("FAIL cont p2 valid cycles got %0d expected %0d", nvalid, L);
    end
    cycle(1'b0, x_12, 1'b1, 1'b0, 1'b1);
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL cont stop busy got %b expected 0", busy);
    end
  endtask
  task automatic test_async_reset();
    clr();
    cycle(1'b1, xa, 1'b0, 1'b0, 1'b0);
    repeat (4) cycle(1'b0, x_0, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({busy, isgen, done, idx, sn} !== '0) begin
      n_fail++;
      $display("FAIL async reset outputs got %b expected 0", {busy, isgen, done, idx, sn});
    end
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    cyc++;
    check_done("async reset", 0, -1);
    test_ones_count();
  endtask
  task automatic test_bw3();
    int q[$];
    int ones, e;
    for (int v = 0; v < 8; v++) begin
      x3 = 3'(v);
      s3 = 1'b1;
      q.push_back(v);
      ones = 0;
      @(posedge clk);
      #1;
      s3 = 1'b0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (g3 && sn3[0]) ones++;
        if (d3 && q.size() > 0) begin
          e = q.pop_front();
          n_chk++;
          if (ones !== e) begin
            n_fail++;
            $display("FAIL bw3 x=%0d ones got %0d expected %0d", v, ones, e);
          end
        end
        @(posedge clk);
        #1;
      end
    end
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL bw3 missing done pulses got %0d pending expected 0", q.size());
    end
  endtask
  task automatic test_bw6();
    int q[$];
    int ones, e;
    for (int v = 0; v < 64; v++) begin
      x6 = 6'(v);
      s6 = 1'b1;
      q.push_back(v);
      ones = 0;
      @(posedge clk);
      #1;
      s6 = 1'b0;
      for (int k = 0; k < 64; k++) begin
        @(negedge clk);
        if (g6 && sn6[0]) ones++;
        if (d6 && q.size() > 0) begin
          e = q.pop_front();
          n_chk++;
          if (ones !== e) begin
            n_fail++;
            $display("FAIL bw6 x=%0d ones got %0d expected %0d", v, ones, e);
          end
        end
        @(posedge clk);
        #1;
      end
    end
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL bw6 missing done pulses got %0d pending expected 0", q.size());
    end
  endtask
  initial begin
    test_reset();
    test_ones_count();
    test_back_to_back();
    test_hold();
    test_stop();
    test_continuous();
    test_async_reset();
    test_bw3();
    test_bw6();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
